lsu: RTL and testbench

Load/store unit in the MIPS datapath, directly downstream of the ALU. It takes the ALU's 32-bit result as the effective address and runs one byte, halfword or word access on a req/ack memory bus. Loads return sign- or zero-extended data for writeback; stores drive byte enables with lane-replicated data. The core stalls on `busy` until `done` pulses.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/lsu_lane_fmt.sv | 74 +++++++
 rtl/lsu.sv | 180 ++++++++++++++++++
 tb/tb_lsu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath definitions used by the load/store unit.
// Holds memory-op encodings, LSU state encoding, byte-enable constants and op screening helpers.
package mips_pkg;

  localparam logic [3:0] MEM_LB  = 4'b0000;
  localparam logic [3:0] MEM_LH  = 4'b0001;
  localparam logic [3:0] MEM_LW  = 4'b0011;
  localparam logic [3:0] MEM_LBU = 4'b0100;
  localparam logic [3:0] MEM_LHU = 4'b0101;
  localparam logic [3:0] MEM_SB  = 4'b1000;
  localparam logic [3:0] MEM_SH  = 4'b1001;
  localparam logic [3:0] MEM_SW  = 4'b1011;

  // Access size lives in mem_op[1:0]; mem_op[2] marks unsigned loads, mem_op[3] marks stores.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
      MEM_SB, MEM_SH, MEM_SW: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op[1:0])
      SZ_HALF: op_misaligned = off[0];
      SZ_WORD: op_misaligned = (off != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [3:0] op, input logic [1:0] off);
    case (op[1:0])
      SZ_HALF: align_off = {off[1], 1'b0};
      SZ_WORD: align_off = 2'b00;
      default: align_off = off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// lsu_lane_fmt: combinational lane steering for the LSU.
// Produces byte enables and replicated store data, and extracts/extends load data.
module lsu_lane_fmt
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and store-data replication by access size
  always_comb begin
    be        = BE_NONE;
    wdata_rep = 32'h0000_0000;
    case (op[1:0])
      SZ_BYTE: begin
        be        = BE_BYTE << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = BE_HALF << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be        = BE_WORD;
        wdata_rep = wdata;
      end
      default: begin
        be        = BE_NONE;
        wdata_rep = 32'h0000_0000;
      end
    endcase
  end

  // Little-endian lane select
  always_comb begin
    byte_s = rdata[7:0];
    case (off)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Load extension; stores return zero
  always_comb begin
    rdata_fmt = 32'h0000_0000;
    if (op[3]) begin
      rdata_fmt = 32'h0000_0000;
    end else begin
      case (op[1:0])
        SZ_BYTE: rdata_fmt = op[2] ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
        SZ_HALF: rdata_fmt = op[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        SZ_WORD: rdata_fmt = rdata;
        default: rdata_fmt = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: MIPS load/store unit running one byte/half/word access on a req/ack bus with timeout.
// Define LSU_MISALIGN_EXC_EN to trap misaligned accesses instead of forcing alignment.
module lsu
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        addr_err,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e    state_r;
  lsu_state_e    state_next_s;
  logic [3:0]    op_r;
  logic [1:0]    off_r;
  logic [29:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;
  logic [CW-1:0] cnt_r;
  logic          addr_err_r;
  logic          bus_err_r;

  logic          bad_s;
  logic [1:0]    off_s;
  logic          timeout_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_rep_s;
  logic [31:0]   rdata_fmt_s;

  lsu_lane_fmt u_lane_fmt (
    .op        (op_r),
    .off       (off_r),
    .wdata     (wdata_r),
    .rdata     (m_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_fmt (rdata_fmt_s)
  );

  // Request screening: illegal ops always trap; misalignment traps or is masked off
  always_comb begin
    bad_s = 1'b0;
    off_s = addr[1:0];
`ifdef LSU_MISALIGN_EXC_EN
    bad_s = !op_legal(mem_op) || op_misaligned(mem_op, addr[1:0]);
    off_s = addr[1:0];
`else
    bad_s = !op_legal(mem_op);
    off_s = align_off(mem_op, addr[1:0]);
`endif
  end

  assign timeout_s = (cnt_r == CW'(TIMEOUT_CYC));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an ack in the timeout cycle still completes normally
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = bad_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (m_ack || timeout_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 4'b0000;
      off_r      <= 2'b00;
      addr_r     <= 30'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      cnt_r      <= {CW{1'b0}};
      addr_err_r <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (start) begin
            op_r       <= mem_op;
            off_r      <= off_s;
            addr_r     <= addr[31:2];
            wdata_r    <= wdata;
            rdata_r    <= 32'h0000_0000;
            addr_err_r <= bad_s;
            bus_err_r  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (m_ack) begin
            rdata_r <= rdata_fmt_s;
          end else if (timeout_s) begin
            rdata_r   <= 32'h0000_0000;
            bus_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          rdata_r    <= 32'h0000_0000;
          addr_err_r <= 1'b0;
          bus_err_r  <= 1'b0;
        end
        default: begin
          rdata_r    <= 32'h0000_0000;
          addr_err_r <= 1'b0;
          bus_err_r  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; bus fields are quiet outside ACCESS
  always_comb begin
    busy      = (state_r != ST_IDLE);
    done      = (state_r == ST_DONE);
    m_req     = (state_r == ST_ACCESS);
    rdata_out = 32'h0000_0000;
    addr_err  = 1'b0;
    bus_err   = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'h0000_0000;
    m_be      = BE_NONE;
    m_wdata   = 32'h0000_0000;
    if (state_r == ST_DONE) begin
      rdata_out = rdata_r;
      addr_err  = addr_err_r;
      bus_err   = bus_err_r;
    end else if (state_r == ST_ACCESS) begin
      m_we    = op_r[3];
      m_addr  = {addr_r, 2'b00};
      m_be    = be_s;
      m_wdata = op_r[3] ? wdata_rep_s : 32'h0000_0000;
    end else begin
      rdata_out = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against an arithmetic reference model.
// Expectations follow LSU_MISALIGN_EXC_EN when the bench is built with it.
module tb_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mem_op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, addr_err, bus_err, m_req, m_we;
  logic [31:0] rdata_out, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata_out(rdata_out), .addr_err(addr_err), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
  endfunction

  function automatic int size_of(input logic [3:0] op);
    if (op[1:0] == 2'd0) return 1;
    if (op[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  // One access: ack_cyc is the cycle (1 = first ACCESS cycle) that acks, 0 means never
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                     input logic [31:0] rd, input int ack_cyc);
    int sz, off, exp_done;
    bit bad, timed_out, got;
    logic [31:0] ea, ebe, ewd, erd, mask, v;
    sz  = size_of(op);
    bad = !legal(op);
`ifdef LSU_MISALIGN_EXC_EN
    if (legal(op) && (a % sz) != 0) bad = 1'b1;
    ea = a;
`else
    ea = a - (a % sz);
`endif
    off = int'(ea % 4);
    ebe = ((32'd1 << sz) - 32'd1) << off;
    if (sz == 1)      ewd = 32'(w[7:0]) * 32'h0101_0101;
    else if (sz == 2) ewd = 32'(w[15:0]) * 32'h0001_0001;
    else              ewd = w;
    if (!op[3]) begin
      v = rd >> (8 * off);
      if (sz < 4) begin
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!op[2] && v[8*sz-1]) v = v | ~mask;
      end
      erd = v;
    end else begin
      erd = 32'h0;
    end
    timed_out = !(ack_cyc >= 1 && ack_cyc <= T + 1);
    exp_done  = timed_out ? T + 2 : ack_cyc + 1;

    start = 1'b1; mem_op = op; addr = a; wdata = w;
    @(posedge clk); #1;
    start = 1'b0;
    if (bad) begin
      check("err_done", {31'd0, done}, 32'd1);
      check("err_addr_err", {31'd0, addr_err}, 32'd1);
      check("err_bus_err", {31'd0, bus_err}, 32'd0);
      check("err_no_req", {31'd0, m_req}, 32'd0);
      @(posedge clk); #1;
      check("err_idle", {29'd0, busy, done, addr_err}, 32'd0);
      return;
    end
    got = 1'b0;
    for (int c = 1; c <= T + 3; c++) begin
      if (done) begin
        check("done_cycle", 32'(c), 32'(exp_done));
        check("rdata_out", rdata_out, timed_out ? 32'h0 : erd);
        check("bus_err", {31'd0, bus_err}, {31'd0, timed_out});
        check("addr_err", {31'd0, addr_err}, 32'd0);
        check("req_low_done", {31'd0, m_req}, 32'd0);
        got = 1'b1;
        break;
      end
      check("m_req", {31'd0, m_req}, 32'd1);
      if (c == 1 || c == ack_cyc) begin
        check("m_addr", m_addr, {ea[31:2], 2'b00});
        check("m_be", {28'd0, m_be}, ebe);
        check("m_we", {31'd0, m_we}, {31'd0, op[3]});
        if (op[3]) check("m_wdata", m_wdata, ewd);
      end
      if (c == 1) begin
        start = 1'b1; mem_op = 4'h3; addr = ~a; wdata = ~w;
      end else begin
        start = 1'b0;
      end
      m_ack   = (c == ack_cyc);
      m_rdata = (c == ack_cyc) ? rd : $urandom;
      @(posedge clk); #1;
    end
    m_ack = 1'b0; start = 1'b0;
    if (!got) check("done_seen", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("idle_after", {29'd0, busy, done, bus_err}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_flags", {26'd0, busy, done, m_req, m_we, addr_err, bus_err}, 32'd0);
    check("rst_rdata", rdata_out, 32'h0);
    check("rst_bus", m_addr | m_wdata | {28'd0, m_be}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(4'hB, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 1);
    run(4'h0, 32'h1000_0003, 32'h0, 32'h80FF_FF7F, 2);
    run(4'h4, 32'h1000_0003, 32'h0, 32'h80FF_FF7F, 1);
    run(4'h9, 32'h1000_0002, 32'h1234_ABCD, 32'h0, 1);
    run(4'h3, 32'h1000_0001, 32'h0, 32'hCAFE_F00D, 1);
    run(4'h1, 32'h2000_0003, 32'h0, 32'h8001_7FFF, 3);
    run(4'h3, 32'h3000_0000, 32'h0, 32'h1111_2222, 0);
    run(4'h5, 32'h3000_0002, 32'h0, 32'h9ABC_0000, T + 1);
    run(4'h2, 32'h4000_0000, 32'h0, 32'h0, 1);

    // Stray ack while idle must not start anything
    m_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ack = 1'b0;
    check("stray_ack", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      else op = ops[$urandom_range(0, 7)];
      run(op, $urandom, $urandom, $urandom, int'($urandom_range(0, T + 1)));
    end

    // Reset in the middle of an access
    start = 1'b1; mem_op = 4'h3; addr = 32'h5000_0004; wdata = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", {31'd0, m_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", {30'd0, m_req, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no_done_after_rst", {30'd0, done, busy}, 32'd0);
      @(posedge clk); #1;
    end
    run(4'h3, 32'h5000_0004, 32'h0, 32'h7654_3210, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
